// File: rtl/mem_model_pkg.sv
// mem_model_pkg: shared types and width helpers for the mem_model_hs memory model.
//   state_t         : init-sweep FSM states (INIT, READY)
//   be_width()      : byte-enable width for a given data width
//   init_cnt_width(): init-sweep counter width for a given depth (at least 1)
package mem_model_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned init_cnt_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_model_hs_if.sv
// mem_model_hs_if: request/response handshake bundle for mem_model_hs.
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request channel
//   rsp_valid/rsp_ready/rsp_rdata                        : read response channel
//   rsp_err (only with MEM_MODEL_ERR_RESP_EN)            : response error flag
// Modports: master (requester side), slave (memory side).
interface mem_model_hs_if
  import mem_model_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_we;
  logic [ADDR_WIDTH-1:0]             req_addr;
  logic [DATA_WIDTH-1:0]             req_wdata;
  logic [be_width(DATA_WIDTH)-1:0]   req_be;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [DATA_WIDTH-1:0]             rsp_rdata;
`ifdef MEM_MODEL_ERR_RESP_EN
  logic                              rsp_err;
`endif

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
`ifdef MEM_MODEL_ERR_RESP_EN
    input  rsp_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
`ifdef MEM_MODEL_ERR_RESP_EN
    output rsp_err,
`endif
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: LATENCY-stage valid/data pipeline with a single global stall.
//   clk, reset          : clock, synchronous active-high reset (clears valids and data)
//   stall               : when high every stage holds its contents
//   in_valid, in_data   : loaded into stage 0 when not stalled
//   out_valid, out_data : last stage
module mem_rd_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             vld [LATENCY];
  logic [WIDTH-1:0] dat [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else if (!stall) begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/mem_model_hs.sv
// mem_model_hs: single-port memory model with valid/ready request and response
// handshakes, byte-enable writes, RD_LATENCY-cycle read pipeline with response
// backpressure, and a post-reset sweep that writes INIT_VALUE to every word.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_model_hs_if.slave (request and response channels)
//   init_done  : high once the init sweep has completed
//   err_seen   : (MEM_MODEL_ERR_RESP_EN only) sticky out-of-range write flag
// Optional feature macro: MEM_MODEL_ERR_RESP_EN (out-of-range reads respond with
// rsp_err=1 and zero data; out-of-range writes set err_seen).
module mem_model_hs
  import mem_model_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 256,
  parameter int unsigned           RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic           clk,
  input  logic           reset,
  mem_model_hs_if.slave  bus,
`ifdef MEM_MODEL_ERR_RESP_EN
  output logic           err_seen,
`endif
  output logic           init_done
);

  localparam int unsigned BE_W  = be_width(DATA_WIDTH);
  localparam int unsigned CNT_W = init_cnt_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(DEPTH - 1);
`ifdef MEM_MODEL_ERR_RESP_EN
  localparam int unsigned PIPE_W = DATA_WIDTH + 1;
`else
  localparam int unsigned PIPE_W = DATA_WIDTH;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    stall;
  logic                    req_acc;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    in_range;
  logic [CNT_W-1:0]        idx;
  logic [PIPE_W-1:0]       pipe_in;
  logic [PIPE_W-1:0]       pipe_out;
  logic                    pipe_vld;

  // Response backpressure freezes the whole read pipeline, so no new request
  // may be taken while the head response is waiting.
  assign stall         = pipe_vld && !bus.rsp_ready;
  assign bus.req_ready = (state == READY) && !stall;
  assign req_acc       = bus.req_valid && bus.req_ready;
  assign wr_acc        = req_acc && bus.req_we;
  assign rd_acc        = req_acc && !bus.req_we;
  assign in_range      = {1'b0, bus.req_addr} < DEPTH_LIM;
  // Truncation is safe: idx is only used when in_range holds.
  assign idx           = bus.req_addr[CNT_W-1:0];

  always_comb begin
`ifdef MEM_MODEL_ERR_RESP_EN
    pipe_in = {1'b1, {DATA_WIDTH{1'b0}}};
    if (in_range) begin
      pipe_in = {1'b0, mem[idx]};
    end
`else
    pipe_in = INIT_VALUE;
    if (in_range) begin
      pipe_in = mem[idx];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (init_cnt == LAST_IDX) begin
            state     <= READY;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        READY: state <= READY;
        default: state <= INIT;
      endcase
    end
  end

  // Storage has no reset; contents are restored by the sweep after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_cnt] <= INIT_VALUE;
      end else if (wr_acc && in_range) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (bus.req_be[b]) begin
            mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef MEM_MODEL_ERR_RESP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_seen <= 1'b0;
    end else if (wr_acc && !in_range) begin
      err_seen <= 1'b1;
    end
  end
`endif

  mem_rd_pipe #(
    .WIDTH   (PIPE_W),
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .in_valid  (rd_acc),
    .in_data   (pipe_in),
    .out_valid (pipe_vld),
    .out_data  (pipe_out)
  );

  assign bus.rsp_valid = pipe_vld;
  assign bus.rsp_rdata = pipe_out[DATA_WIDTH-1:0];
`ifdef MEM_MODEL_ERR_RESP_EN
  assign bus.rsp_err   = pipe_out[DATA_WIDTH];
`endif

endmodule
